adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 163 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - two-requester arbiter sharing one registered 32-bit prefix adder

// 32-bit Kogge-Stone adder: generate/propagate prefix tree, carry-in tied to 0.
module prefix_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Five prefix levels (span 1,2,4,8,16); g[i] ends as the carry out of bits [i:0].
  function automatic logic [32:0] ks_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] g, p, gn, pn, hp;
    g  = a & b;
    p  = a ^ b;
    hp = p;
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << l)) begin
          gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
          pn[i] = p[i] & p[i - (1 << l)];
        end else begin
          gn[i] = g[i];
          pn[i] = p[i];
        end
      end
      g = gn;
      p = pn;
    end
    return {g[31], hp ^ {g[30:0], 1'b0}};
  endfunction

  assign {cout_o, sum_o} = ks_add(a_i, b_i);

endmodule

module adder_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic        id_q, id_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] res_sum_q, res_sum_d;
  logic        res_cout_q, res_cout_d;
  logic        res_id_q, res_id_d;
  logic        res_valid_q, res_valid_d;

  logic [31:0] add_sum;
  logic        add_cout;
  logic        accept_win, accept, grant_id;

  // The only adder: it sees registered operands, never the raw request ports.
  prefix_adder32 u_adder (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Grant decision; ready is masked by rst because the reset is asynchronous.
  always_comb begin
    accept_win = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & res_ready));
    if (req0_valid & req1_valid)
      grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
    else
      grant_id = req1_valid;
    accept = accept_win & (req0_valid | req1_valid);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_id_q     <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_sum_q    <= res_sum_d;
      res_cout_q   <= res_cout_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
    end
  end

  // Next state: capture on accept, latch adder in CALC, retire in HOLD.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        res_sum_d   = add_sum;
        res_cout_d  = add_cout;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = accept ? CALC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_a_d       = grant_id ? req1_a : req0_a;
      op_b_d       = grant_id ? req1_b : req0_b;
      id_d         = grant_id;
      last_grant_d = grant_id;
    end
  end

  // Outputs: one-hot ready toward the granted requester, results straight from registers.
  always_comb begin
    req0_ready = accept & ~grant_id;
    req1_ready = accept & grant_id;
    res_valid  = res_valid_q;
    res_sum    = res_sum_q;
    res_cout   = res_cout_q;
    res_id     = res_id_q;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed vectors, corner sequences and scoreboard for adder_arbiter

module tb_adder_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, res_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        r_req0_ready, r_req1_ready, r_res_valid, r_res_cout, r_res_id;
  logic [31:0] r_res_sum;
  logic        f_req0_ready, f_req1_ready, f_res_valid, f_res_cout, f_res_id;
  logic [31:0] f_res_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r_req1_ready),
    .res_valid(r_res_valid), .res_ready(res_ready), .res_sum(r_res_sum),
    .res_cout(r_res_cout), .res_id(r_res_id)
  );

  adder_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f_req1_ready),
    .res_valid(f_res_valid), .res_ready(res_ready), .res_sum(f_res_sum),
    .res_cout(f_res_cout), .res_id(f_res_id)
  );

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];

  logic [33:0] exp_r [$];
  logic [33:0] exp_f [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic sb_cycle();
    logic [33:0] e;
    if (r_res_valid && res_ready) begin
      if (exp_r.size() == 0) chk("rnd_rr_spurious", 1, 0);
      else begin
        e = exp_r.pop_front();
        chk("rnd_rr_result", {r_res_id, r_res_cout, r_res_sum}, e);
      end
    end
    if (f_res_valid && res_ready) begin
      if (exp_f.size() == 0) chk("rnd_fp_spurious", 1, 0);
      else begin
        e = exp_f.pop_front();
        chk("rnd_fp_result", {f_res_id, f_res_cout, f_res_sum}, e);
      end
    end
    if (r_req0_ready) exp_r.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
    if (r_req1_ready) exp_r.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
    if (f_req0_ready) exp_f.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}});
    if (f_req1_ready) exp_f.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}});
    if (r_req0_ready && r_req1_ready) chk("rnd_rr_both_ready", 1, 0);
    if (f_req1_ready && req0_valid) chk("rnd_fp_prio", 1, 0);
    if ((r_req0_ready && !req0_valid) || (r_req1_ready && !req1_valid)) chk("rnd_rr_ready_no_valid", 1, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
    vecs[5] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // reset state, with both requesters already asking
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h1; req0_b = 32'h1; req1_a = 32'h2; req1_b = 32'h2;
    #1;
    chk("rst_ready0", r_req0_ready, 0);
    chk("rst_ready1", r_req1_ready, 0);
    chk("rst_valid", r_res_valid, 0);
    chk("rst_sum", r_res_sum, 0);
    chk("rst_cout", r_res_cout, 0);
    chk("rst_id", r_res_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // single-requester vectors
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].id) begin
        req1_valid = 1'b1; req1_a = vecs[k].a; req1_b = vecs[k].b;
      end else begin
        req0_valid = 1'b1; req0_a = vecs[k].a; req0_b = vecs[k].b;
      end
      #1;
      chk("vec_ready", vecs[k].id ? r_req1_ready : r_req0_ready, 1);
      chk("vec_other_ready", vecs[k].id ? r_req0_ready : r_req1_ready, 0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 32'hDEAD_BEEF; req1_a = 32'hDEAD_BEEF;
      chk("vec_calc_valid", r_res_valid, 0);
      step();
      chk("vec_valid", r_res_valid, 1);
      chk("vec_sum", r_res_sum, vecs[k].sum);
      chk("vec_cout", r_res_cout, vecs[k].cout);
      chk("vec_id", r_res_id, vecs[k].id);
      chk("vec_fp_sum", f_res_sum, vecs[k].sum);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("vec_retired", r_res_valid, 0);
    end

    // continuous tie: round-robin vs fixed priority
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd1;   req0_b = 32'd2;
    req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200;
    res_ready = 1'b1;
    #1;
    chk("rr_first_ready0", r_req0_ready, 1);
    chk("fp_first_ready0", f_req0_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_calc_valid", r_res_valid, 0);
      step();
      chk("rr_valid", r_res_valid, 1);
      chk("rr_id", r_res_id, k % 2);
      chk("rr_sum", r_res_sum, (k % 2) ? 32'd300 : 32'd3);
      chk("rr_next_ready", (k % 2) ? r_req0_ready : r_req1_ready, 1);
      chk("fp_id", f_res_id, 0);
      chk("fp_sum", f_res_sum, 32'd3);
      chk("fp_ready1", f_req1_ready, 0);
    end

    // backpressure in HOLD, then retire + accept in one cycle
    do_reset();
    res_ready = 1'b0;
    req0_a = 32'h1111_1111; req0_b = 32'h2222_2222;
    req1_a = 32'hF000_0000; req1_b = 32'h2000_0000;
    step();
    step();
    chk("bp_valid", r_res_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", r_res_valid, 1);
      chk("bp_hold_sum", r_res_sum, 32'h3333_3333);
      chk("bp_hold_id", r_res_id, 0);
      chk("bp_ready0", r_req0_ready, 0);
      chk("bp_ready1", r_req1_ready, 0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("bp_accept1", r_req1_ready, 1);
    chk("bp_accept0", r_req0_ready, 0);
    step();
    res_ready = 1'b0;
    chk("bp_calc_valid", r_res_valid, 0);
    step();
    chk("bp_next_valid", r_res_valid, 1);
    chk("bp_next_id", r_res_id, 1);
    chk("bp_next_sum", r_res_sum, 32'h1000_0000);
    chk("bp_next_cout", r_res_cout, 1);

    // asynchronous reset during HOLD
    do_reset();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    res_ready = 1'b0;
    step();
    step();
    chk("ar_hold_valid", r_res_valid, 1);
    chk("ar_hold_sum", r_res_sum, 32'd7);
    req1_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_drop", r_res_valid, 0);
    chk("ar_sum_drop", r_res_sum, 0);
    chk("ar_ready0", r_req0_ready, 0);
    chk("ar_ready1", r_req1_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("ar_tie_ready0", r_req0_ready, 1);
    chk("ar_tie_ready1", r_req1_ready, 0);

    // random traffic against per-DUT in-order scoreboards
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = $urandom; req0_b = $urandom;
      req1_a = $urandom; req1_b = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      sb_cycle();
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      sb_cycle();
      step();
    end
    chk("rnd_rr_drain", exp_r.size(), 0);
    chk("rnd_fp_drain", exp_f.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
